// File: rtl/adder_key_scheduler.sv
// rtl/adder_key_scheduler.sv - two-requester round-robin scheduler for a key-locked external 16-bit adder
// Owns the serial key load, arbitration, operand hold/settle timing and the registered response.
module adder_key_scheduler #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [31:0] RESET_KEY     = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        key_bit_i,
    input  logic        key_shift_i,
    input  logic        key_commit_i,
    input  logic        req0_valid_i,
    input  logic [15:0] req0_a_i,
    input  logic [15:0] req0_b_i,
    input  logic        req1_valid_i,
    input  logic [15:0] req1_a_i,
    input  logic [15:0] req1_b_i,
    output logic        req0_ready_o,
    output logic        req1_ready_o,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [16:0] rsp_sum_o,
    output logic [15:0] adder_a_o,
    output logic [15:0] adder_b_o,
    output logic [31:0] adder_key_o,
    input  logic [16:0] adder_sum_i,
    output logic        busy_o,
    output logic        key_err_o
);

    typedef enum logic [1:0] {NOKEY, IDLE, EXEC, RESP} state_e;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_e      state_q, state_d;
    logic [31:0] shadow_q, key_q;
    logic        last_grant_q;
    logic [3:0]  cnt_q;
    logic [15:0] a_q, b_q;
    logic        id_q;
    logic [16:0] sum_q;
    logic        key_err_q;

    logic grant_any, grant_id, commit_ok, settle_done;

    always_comb begin
        grant_any   = (state_q == IDLE) && (req0_valid_i || req1_valid_i);
        // Under contention the requester not served last wins; otherwise whoever is valid.
        grant_id    = (req0_valid_i && req1_valid_i) ? ~last_grant_q : req1_valid_i;
        commit_ok   = key_commit_i && ((state_q == NOKEY) || (state_q == IDLE));
        settle_done = (cnt_q <= 4'd1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            NOKEY: if (commit_ok)   state_d = IDLE;
            IDLE:  if (grant_any)   state_d = EXEC;
            EXEC:  if (settle_done) state_d = RESP;
            RESP:  if (rsp_ready_i) state_d = IDLE;
            default:                state_d = NOKEY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= NOKEY;
            shadow_q     <= 32'h0;
            key_q        <= RESET_KEY;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            a_q          <= 16'h0;
            b_q          <= 16'h0;
            id_q         <= 1'b0;
            sum_q        <= 17'h0;
            key_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (key_shift_i) shadow_q <= {shadow_q[30:0], key_bit_i};
            if (commit_ok) key_q <= shadow_q;
            if (key_commit_i && !commit_ok) key_err_q <= 1'b1;
            if (grant_any) begin
                last_grant_q <= grant_id;
                id_q         <= grant_id;
                a_q          <= grant_id ? req1_a_i : req0_a_i;
                b_q          <= grant_id ? req1_b_i : req0_b_i;
                cnt_q        <= SETTLE_INIT;
            end else if (state_q == EXEC) begin
                if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                if (settle_done) sum_q <= adder_sum_i;
            end
        end
    end

    always_comb begin
        req0_ready_o = grant_any && !grant_id;
        req1_ready_o = grant_any && grant_id;
        rsp_valid_o  = (state_q == RESP);
        busy_o       = (state_q == EXEC) || (state_q == RESP);
        rsp_id_o     = id_q;
        rsp_sum_o    = sum_q;
        adder_a_o    = a_q;
        adder_b_o    = b_q;
        adder_key_o  = key_q;
        key_err_o    = key_err_q;
    end

endmodule
